// File: rtl/line_buffer_taps_if.sv
// Pixel stream in, vertical tap column out, for the line buffer.
// Master drives the raster stream; slave is the line buffer itself.
interface line_buffer_taps_if #(
    parameter int DATA_W    = 10,
    parameter int NUM_LINES = 2,
    parameter int ADDR_W    = 11
);
    logic                            frame_start;
    logic                            in_valid;
    logic [DATA_W-1:0]               in_data;
    logic                            out_valid;
    logic [DATA_W*(NUM_LINES+1)-1:0] taps;
    logic [ADDR_W-1:0]               out_col;
    logic [15:0]                     out_row;
    logic                            lines_ready;

    modport master (
        output frame_start, in_valid, in_data,
        input  out_valid, taps, out_col, out_row, lines_ready
    );

    modport slave (
        input  frame_start, in_valid, in_data,
        output out_valid, taps, out_col, out_row, lines_ready
    );
endinterface

// File: rtl/line_buffer_taps.sv
// Multi-line buffer: emits current pixel plus NUM_LINES pixels above it,
// masking rows not yet filled since the last frame start.
module line_buffer_taps #(
    parameter int DATA_W    = 10,
    parameter int LINE_LEN  = 1280,
    parameter int NUM_LINES = 2,
    parameter int ADDR_W    = 11
) (
    input  logic clk,
    input  logic rst_n,
    line_buffer_taps_if.slave bus
);
    localparam int TW = DATA_W * (NUM_LINES + 1);
    localparam logic [ADDR_W-1:0] LAST_COL = ADDR_W'(LINE_LEN - 1);

    logic [ADDR_W-1:0] r_col;
    logic [15:0]       r_row;
    logic              r_gen;

    logic [ADDR_W-1:0] w_col;
    logic [15:0]       w_row;
    logic              w_gen;
    logic [ADDR_W-1:0] w_col_nxt;
    logic [15:0]       w_row_nxt;

    logic              r_v1;
    logic [DATA_W-1:0] r_d1;
    logic [ADDR_W-1:0] r_col1;
    logic [15:0]       r_row1;
    logic              r_gen1;

    logic [DATA_W-1:0] w_rd [NUM_LINES];
    logic [DATA_W-1:0] w_wr [NUM_LINES];
    logic [TW-1:0]     w_taps;

    logic              r_out_valid;
    logic [TW-1:0]     r_taps;
    logic [ADDR_W-1:0] r_out_col;
    logic [15:0]       r_out_row;
    logic              r_lines_ready;

    // frame_start retags the pixel sampled in the same cycle
    always_comb begin
        w_col     = bus.frame_start ? '0 : r_col;
        w_row     = bus.frame_start ? '0 : r_row;
        w_gen     = bus.frame_start ? ~r_gen : r_gen;
        w_col_nxt = (w_col == LAST_COL) ? '0 : w_col + ADDR_W'(1);
        w_row_nxt = w_row;
        if (w_col == LAST_COL && w_row != 16'hFFFF) begin
            w_row_nxt = w_row + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_col <= '0;
            r_row <= '0;
            r_gen <= 1'b0;
        end else begin
            r_gen <= w_gen;
            if (bus.in_valid) begin
                r_col <= w_col_nxt;
                r_row <= w_row_nxt;
            end else begin
                r_col <= w_col;
                r_row <= w_row;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_v1   <= 1'b0;
            r_d1   <= '0;
            r_col1 <= '0;
            r_row1 <= '0;
            r_gen1 <= 1'b0;
        end else begin
            r_v1 <= bus.in_valid;
            if (bus.in_valid) begin
                r_d1   <= bus.in_data;
                r_col1 <= w_col;
                r_row1 <= w_row;
                r_gen1 <= w_gen;
            end
        end
    end

    // Read in stage 0, write one cycle later: the column shifts down a line
    for (genvar k = 0; k < NUM_LINES; k++) begin : g_line
        logic [DATA_W-1:0] r_mem [LINE_LEN];
        logic [DATA_W-1:0] r_rd;

        if (k == 0) begin : g_first
            assign w_wr[k] = r_d1;
        end else begin : g_rest
            assign w_wr[k] = w_rd[k-1];
        end

        always_ff @(posedge clk) begin
            if (bus.in_valid) begin
                r_rd <= r_mem[w_col];
            end
            if (r_v1) begin
                r_mem[r_col1] <= w_wr[k];
            end
        end

        assign w_rd[k] = r_rd;
    end

    always_comb begin
        w_taps = '0;
        w_taps[0 +: DATA_W] = r_d1;
        for (int k = 1; k <= NUM_LINES; k++) begin
            if (r_row1 >= 16'(k)) begin
                w_taps[k*DATA_W +: DATA_W] = w_rd[k-1];
            end
        end
    end

    // Old-generation pixels draining after frame_start must not set ready
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out_valid   <= 1'b0;
            r_taps        <= '0;
            r_out_col     <= '0;
            r_out_row     <= '0;
            r_lines_ready <= 1'b0;
        end else begin
            r_out_valid <= r_v1;
            if (r_v1) begin
                r_taps    <= w_taps;
                r_out_col <= r_col1;
                r_out_row <= r_row1;
            end
            if (bus.frame_start) begin
                r_lines_ready <= 1'b0;
            end else if (r_v1 && r_gen1 == r_gen &&
                         r_row1 >= 16'(NUM_LINES)) begin
                r_lines_ready <= 1'b1;
            end
        end
    end

    assign bus.out_valid   = r_out_valid;
    assign bus.taps        = r_taps;
    assign bus.out_col     = r_out_col;
    assign bus.out_row     = r_out_row;
    assign bus.lines_ready = r_lines_ready;
endmodule

// File: tb/tb_line_buffer_taps.sv
// Scoreboard bench for line_buffer_taps: small (4x2) and full (1280x4)
// instances driven from one initial block, scenarios as tasks.
module tb_line_buffer_taps;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    line_buffer_taps_if #(.DATA_W(10), .NUM_LINES(2), .ADDR_W(2))  ia ();
    line_buffer_taps_if #(.DATA_W(10), .NUM_LINES(4), .ADDR_W(11)) ib ();

    line_buffer_taps #(
        .DATA_W(10), .LINE_LEN(4), .NUM_LINES(2), .ADDR_W(2)
    ) dut_a (.clk(clk), .rst_n(rst_n), .bus(ia.slave));

    line_buffer_taps #(
        .DATA_W(10), .LINE_LEN(1280), .NUM_LINES(4), .ADDR_W(11)
    ) dut_b (.clk(clk), .rst_n(rst_n), .bus(ib.slave));

    typedef struct packed {
        logic [49:0] taps;
        logic [10:0] col;
        logic [15:0] row;
        logic        lr;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    int m_col[2];
    int m_row[2];
    int m_fr[2];
    logic [9:0] m_pix [longint];
    int n_cmp = 0;
    int n_err = 0;
    exp_t ea_last;
    bit have_last = 0;

    function automatic longint pkey(int dut, int fr, int r, int c);
        return (((longint'(dut) * 1024 + longint'(fr)) * 65536
                 + longint'(r)) * 4096 + longint'(c));
    endfunction

    function automatic exp_t obs_a();
        exp_t o;
        o.taps = 50'(ia.taps);
        o.col  = 11'(ia.out_col);
        o.row  = ia.out_row;
        o.lr   = ia.lines_ready;
        return o;
    endfunction

    function automatic exp_t obs_b();
        exp_t o;
        o.taps = ib.taps;
        o.col  = ib.out_col;
        o.row  = ib.out_row;
        o.lr   = ib.lines_ready;
        return o;
    endfunction

    // Drive one cycle of stimulus and record what the output must become
    task automatic drive(input int dut, input logic fs,
                         input logic v, input logic [9:0] d);
        exp_t e;
        int nl;
        int ll;
        nl = (dut == 0) ? 2 : 4;
        ll = (dut == 0) ? 4 : 1280;
        if (dut == 0) begin
            ia.frame_start = fs; ia.in_valid = v; ia.in_data = d;
        end else begin
            ib.frame_start = fs; ib.in_valid = v; ib.in_data = d;
        end
        if (fs) begin
            m_fr[dut]++;
            m_col[dut] = 0;
            m_row[dut] = 0;
        end
        if (v) begin
            m_pix[pkey(dut, m_fr[dut], m_row[dut], m_col[dut])] = d;
            e = '0;
            e.taps[9:0] = d;
            for (int k = 1; k <= nl; k++) begin
                if (m_row[dut] >= k) begin
                    e.taps[k*10 +: 10] =
                        m_pix[pkey(dut, m_fr[dut], m_row[dut]-k, m_col[dut])];
                end
            end
            e.col = 11'(m_col[dut]);
            e.row = 16'(m_row[dut]);
            e.lr  = (m_row[dut] >= nl);
            if (dut == 0) qa.push_back(e);
            else          qb.push_back(e);
            if (m_col[dut] == ll - 1) begin
                m_col[dut] = 0;
                m_row[dut]++;
            end else begin
                m_col[dut]++;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(0, 0, 0, 0);
        drive(1, 0, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (ia.out_valid !== 1'b0 || ib.out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_valid: got %b/%b want 0/0",
                     ia.out_valid, ib.out_valid);
        end
        n_cmp++;
        if (ia.taps !== 30'd0 || ib.taps !== 50'd0) begin
            n_err++;
            $display("FAIL reset_taps: got %h/%h want 0", ia.taps, ib.taps);
        end
        n_cmp++;
        if (ia.out_col !== 2'd0 || ia.out_row !== 16'd0 ||
            ia.lines_ready !== 1'b0) begin
            n_err++;
            $display("FAIL reset_tags: got col=%0d row=%0d lr=%b want 0",
                     ia.out_col, ia.out_row, ia.lines_ready);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_stream();
        exp_t ea;
        exp_t oa;
        for (int i = 0; i < 14; i++) begin
            drive(0, i == 0, i < 12, 10'(16 * (i / 4) + (i % 4)));
            @(posedge clk);
            #1;
            if (ia.out_valid) begin
                n_cmp++;
                if (qa.size() == 0) begin
                    n_err++;
                    $display("FAIL sb_stream: unexpected out_valid");
                end else begin
                    ea = qa.pop_front();
                    oa = obs_a();
                    if (oa !== ea) begin
                        n_err++;
                        $display("FAIL sb_stream: got %h want %h", oa, ea);
                    end
                    ea_last = ea;
                    have_last = 1;
                end
            end
            if (i == 0 || i == 1) begin
                n_cmp++;
                if (ia.out_valid !== (i == 1)) begin
                    n_err++;
                    $display("FAIL latency: cycle %0d got %b want %b",
                             i, ia.out_valid, i == 1);
                end
            end
            if (i == 7) begin
                n_cmp++;
                if (ia.taps !== {10'd0, 10'd2, 10'd18}) begin
                    n_err++;
                    $display("FAIL r1c2_taps: got %h want %h",
                             ia.taps, {10'd0, 10'd2, 10'd18});
                end
            end
            if (i == 8 || i == 9) begin
                n_cmp++;
                if (ia.lines_ready !== (i == 9)) begin
                    n_err++;
                    $display("FAIL lines_ready_rise: cycle %0d got %b want %b",
                             i, ia.lines_ready, i == 9);
                end
            end
            if (i == 12) begin
                n_cmp++;
                if (ia.taps !== {10'd3, 10'd19, 10'd35} ||
                    ia.lines_ready !== 1'b1) begin
                    n_err++;
                    $display("FAIL r2c3_taps: got %h lr=%b want %h lr=1",
                             ia.taps, ia.lines_ready,
                             {10'd3, 10'd19, 10'd35});
                end
            end
        end
    endtask

    task automatic test_gaps();
        exp_t ea;
        exp_t oa;
        logic v_prev;
        logic v;
        v_prev = 1'b0;
        for (int i = 0; i < 28; i++) begin
            v = (i >= 2 && i < 26 && ((i - 2) % 2 == 0));
            drive(0, i == 2, v, 10'(16 * (((i - 2) / 2) / 4)
                                   + (((i - 2) / 2) % 4)));
            @(posedge clk);
            #1;
            n_cmp++;
            if (ia.out_valid !== v_prev) begin
                n_err++;
                $display("FAIL gap_valid: cycle %0d got %b want %b",
                         i, ia.out_valid, v_prev);
            end
            if (ia.out_valid) begin
                n_cmp++;
                if (qa.size() == 0) begin
                    n_err++;
                    $display("FAIL sb_gaps: unexpected out_valid");
                end else begin
                    ea = qa.pop_front();
                    oa = obs_a();
                    if (oa !== ea) begin
                        n_err++;
                        $display("FAIL sb_gaps: got %h want %h", oa, ea);
                    end
                    ea_last = ea;
                    have_last = 1;
                end
            end else if (have_last) begin
                n_cmp++;
                if (ia.taps !== ea_last.taps[29:0] ||
                    ia.out_col !== ea_last.col[1:0] ||
                    ia.out_row !== ea_last.row) begin
                    n_err++;
                    $display("FAIL gap_hold: got %h/%0d/%0d want %h/%0d/%0d",
                             ia.taps, ia.out_col, ia.out_row,
                             ea_last.taps[29:0], ea_last.col, ea_last.row);
                end
            end
            v_prev = v;
        end
    endtask

    task automatic test_midline_fs();
        exp_t ea;
        exp_t oa;
        logic fs;
        logic [9:0] d;
        for (int i = 0; i < 21; i++) begin
            fs = (i == 0 || i == 6);
            if (i < 6)       d = 10'(16 * (i / 4) + (i % 4));
            else if (i == 6) d = 10'd18;
            else             d = 10'(256 + 16 * ((i - 6) / 4) + ((i - 6) % 4));
            drive(0, fs, i < 19, d);
            @(posedge clk);
            #1;
            if (ia.out_valid) begin
                n_cmp++;
                if (qa.size() == 0) begin
                    n_err++;
                    $display("FAIL sb_midfs: unexpected out_valid");
                end else begin
                    ea = qa.pop_front();
                    oa = obs_a();
                    if (oa !== ea) begin
                        n_err++;
                        $display("FAIL sb_midfs: got %h want %h", oa, ea);
                    end
                    ea_last = ea;
                end
            end
            if (i == 0) begin
                n_cmp++;
                if (ia.lines_ready !== 1'b0) begin
                    n_err++;
                    $display("FAIL fs_clears_ready: got %b want 0",
                             ia.lines_ready);
                end
            end
            if (i == 7) begin
                n_cmp++;
                if (ia.out_row !== 16'd0 || ia.out_col !== 2'd0 ||
                    ia.taps !== {10'd0, 10'd0, 10'd18} ||
                    ia.lines_ready !== 1'b0) begin
                    n_err++;
                    $display("FAIL midfs_pixel: got r=%0d c=%0d %h lr=%b want r=0 c=0 %h lr=0",
                             ia.out_row, ia.out_col, ia.taps, ia.lines_ready,
                             {10'd0, 10'd0, 10'd18});
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        exp_t ea;
        exp_t oa;
        for (int i = 0; i < 10; i++) begin
            drive(0, i == 0, 1'b1, 10'(16 * (i / 4) + (i % 4)));
            @(posedge clk);
            #1;
            if (ia.out_valid) begin
                n_cmp++;
                if (qa.size() == 0) begin
                    n_err++;
                    $display("FAIL sb_rst1: unexpected out_valid");
                end else begin
                    ea = qa.pop_front();
                    oa = obs_a();
                    if (oa !== ea) begin
                        n_err++;
                        $display("FAIL sb_rst1: got %h want %h", oa, ea);
                    end
                end
            end
        end
        rst_n = 1'b0;
        drive(0, 0, 0, 0);
        @(posedge clk);
        #1;
        n_cmp++;
        if (ia.out_valid !== 1'b0 || ia.taps !== 30'd0 ||
            ia.lines_ready !== 1'b0) begin
            n_err++;
            $display("FAIL rst_mid: got v=%b taps=%h lr=%b want 0/0/0",
                     ia.out_valid, ia.taps, ia.lines_ready);
        end
        rst_n = 1'b1;
        qa.delete();
        m_col[0] = 0;
        m_row[0] = 0;
        m_fr[0]++;
        for (int i = 0; i < 12; i++) begin
            drive(0, i == 0, i < 10, 10'(512 + 16 * (i / 4) + (i % 4)));
            @(posedge clk);
            #1;
            if (ia.out_valid) begin
                n_cmp++;
                if (qa.size() == 0) begin
                    n_err++;
                    $display("FAIL sb_rst2: unexpected out_valid");
                end else begin
                    ea = qa.pop_front();
                    oa = obs_a();
                    if (oa !== ea) begin
                        n_err++;
                        $display("FAIL sb_rst2: got %h want %h", oa, ea);
                    end
                end
            end
            if (i == 5) begin
                n_cmp++;
                if (ia.taps !== {10'd0, 10'd512, 10'd528}) begin
                    n_err++;
                    $display("FAIL stale_mask: got %h want %h",
                             ia.taps, {10'd0, 10'd512, 10'd528});
                end
            end
        end
    endtask

    task automatic test_rdw();
        exp_t ea;
        exp_t oa;
        for (int i = 0; i < 10; i++) begin
            drive(0, i == 0, i < 8, 10'(64 + 16 * (i / 4) + (i % 4)));
            @(posedge clk);
            #1;
            if (ia.out_valid) begin
                n_cmp++;
                if (qa.size() == 0) begin
                    n_err++;
                    $display("FAIL sb_rdw: unexpected out_valid");
                end else begin
                    ea = qa.pop_front();
                    oa = obs_a();
                    if (oa !== ea) begin
                        n_err++;
                        $display("FAIL sb_rdw: got %h want %h", oa, ea);
                    end
                end
            end
            if (i == 5) begin
                n_cmp++;
                if (ia.taps[19:10] !== 10'd64) begin
                    n_err++;
                    $display("FAIL rdw_tap1: got %0d want 64",
                             ia.taps[19:10]);
                end
            end
        end
    endtask

    task automatic test_wide();
        exp_t eb;
        exp_t ob;
        for (int i = 0; i < 7682; i++) begin
            drive(1, i == 0, i < 7680, 10'($urandom_range(0, 1023)));
            @(posedge clk);
            #1;
            if (ib.out_valid) begin
                n_cmp++;
                if (qb.size() == 0) begin
                    n_err++;
                    $display("FAIL sb_wide: unexpected out_valid");
                end else begin
                    eb = qb.pop_front();
                    ob = obs_b();
                    if (ob !== eb) begin
                        n_err++;
                        $display("FAIL sb_wide: got %h want %h", ob, eb);
                    end
                end
            end
            if (i == 1280 || i == 1281) begin
                n_cmp++;
                if (ib.out_col !== ((i == 1280) ? 11'd1279 : 11'd0)) begin
                    n_err++;
                    $display("FAIL col_wrap: cycle %0d got %0d want %0d",
                             i, ib.out_col, (i == 1280) ? 1279 : 0);
                end
            end
        end
    endtask

    initial begin
        m_col = '{0, 0};
        m_row = '{0, 0};
        m_fr  = '{0, 0};
        ia.frame_start = 1'b0; ia.in_valid = 1'b0; ia.in_data = '0;
        ib.frame_start = 1'b0; ib.in_valid = 1'b0; ib.in_data = '0;
        test_reset();
        test_stream();
        test_gaps();
        test_midline_fs();
        test_reset_mid();
        test_rdw();
        test_wide();
        n_cmp++;
        if (qa.size() != 0 || qb.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d/%0d outputs never arrived, want 0/0",
                     qa.size(), qb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/line_buffer_taps.md
Name: line_buffer_taps

Overview:
- Parametrised multi-line buffer for the CCD edge/filter pipeline.
- Accepts a raster pixel stream and presents one vertical column of NUM_LINES+1 aligned pixels per accepted pixel: the current row plus the NUM_LINES rows above it.
- Generates its own column/row addresses internally, so the filter kernel needs no address logic.
- Masks rows not yet filled after a frame start.

Parameters:
- DATA_W, 10, pixel width in bits
- LINE_LEN, 1280, pixels per line (>=2)
- NUM_LINES, 2, number of stored previous lines (>=1); tap count = NUM_LINES+1
- ADDR_W, 11, column address width; must satisfy 2**ADDR_W >= LINE_LEN

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  synchronous active-low reset
- frame_start  in  1  single-cycle pulse; next accepted pixel is row 0, col 0 of a new frame
- in_valid  in  1  in_data is a valid pixel this cycle
- in_data  in  DATA_W  pixel, raster order
- out_valid  out  1  taps/out_col/out_row valid this cycle
- taps  out  DATA_W*(NUM_LINES+1)  slice k (bits k*DATA_W +: DATA_W) = pixel (row-k, col)
- out_col  out  ADDR_W  column of the tap column presented
- out_row  out  16  row of tap 0, saturating at 65535
- lines_ready  out  1  high once NUM_LINES full lines of the current frame are stored

Behaviour:
- Reset (rst_n=0 at a clock edge): out_valid=0, taps=0, out_col=0, out_row=0, lines_ready=0, internal col/row/fill counters=0, pipeline valid bits cleared.
- RAM contents are not cleared by reset; stale data is never visible because of masking.
- Storage: NUM_LINES line memories, LINE_LEN x DATA_W each, one write port and one read port (inferable as block RAM), all on clk.
- Write pattern: line k is written, at the same column, with the value read from line k-1; line 0 is written with in_data.
- Read-during-write to the same address must return OLD data. The implementation guarantees this by reading one stage ahead of the write.
- Latency: exactly 2 cycles. A pixel accepted at cycle t produces out_valid=1 at t+2.
- out_valid is in_valid delayed by 2 cycles. Gaps in in_valid propagate unchanged.
- When out_valid=0, taps, out_col and out_row hold their last values.
- Column counter: increments on each accepted pixel. At LINE_LEN-1 it wraps to 0 and the row counter increments.
- Masking: tap k outputs 0 when out_row < k (row not yet filled in this frame); otherwise it outputs the stored pixel (out_row-k, out_col).
- lines_ready rises together with out_valid for the first pixel of row NUM_LINES. It stays high until frame_start or reset.
- frame_start:
  - Takes effect at the clock edge where it is sampled: col=0, row=0, lines_ready cleared at that edge.
  - If in_valid is high in the same cycle, that pixel is row 0, col 0 of the new frame.
  - Pixels already in the 2-stage pipeline complete with their old row/col tags.
  - From the first new-frame output onward, masking applies.
- frame_start mid-line: the partial line is abandoned and not counted as a filled row.
- Simultaneous rst_n=0 and frame_start: reset wins.
- Row counter: saturates at 65535. The fill/mask logic only needs saturation at NUM_LINES, so saturation never affects taps.
- No backpressure: the consumer must accept every out_valid cycle.

Test Plan:
- Common setup for all scenarios: DATA_W=10, LINE_LEN=4, NUM_LINES=2. Pixel value = 16*row+col.
1. Reset then frame_start, 12 consecutive pixels:
   - First out_valid exactly 2 cycles after first in_valid.
   - Row 0: taps = {0,0,v}.
   - Row 1 col 2: taps = {0,2,18}.
   - Row 2 col 3: taps = {3,19,35}, lines_ready=1 from row 2 col 0.
2. Same stream with in_valid deasserted every other cycle:
   - Identical tap sequence to scenario 1.
   - out_valid gaps mirror the input gaps with 2-cycle delay.
   - Outputs hold during gaps.
3. Frame_start issued mid row 1 (col 2), coincident with a valid pixel:
   - That pixel reports out_row=0, out_col=0, taps={0,0,v}.
   - lines_ready drops.
   - Prior-frame data never appears unmasked.
4. rst_n low for 1 cycle during row 2:
   - Next cycle out_valid=0, taps=0.
   - After frame_start, rows 0/1 are masked despite the stale RAM contents.
5. LINE_LEN=1280, NUM_LINES=4 build, random pixels over 6 lines:
   - Scoreboard model matches all 5 taps on every out_valid.
   - out_col wraps 1279->0.
6. Read-during-write check, continuous stream with no gaps at the line boundary:
   - Tap 1 at (r=1, col 0) equals pixel (0,0), not (1,0).
